tff_bank_arbiter: RTL and testbench

- Shares one W-bit bank of T flip-flops between two requesters (A, B).
- Each requester can either load a D value or apply a toggle mask. A load is converted to toggle enables as T = D ^ q, the same D-from-T technique used by the team's flip-flop blocks.
- Round-robin arbitration, with an optional bounded lock for back-to-back ownership.
- Sits between simple control agents and a shared status/flag register.

---
 rtl/tff_arb_pkg.sv | 18 +
 rtl/t_ff_bank.sv | 34 +++
 rtl/tff_bank_arbiter.sv | 145 ++++++++++++++
 tb/tb_tff_bank_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tff_arb_pkg.sv
// Shared encodings for the T flip-flop bank arbiter.
package tff_arb_pkg;

   // Requester operation encoding
   localparam logic OP_LOAD   = 1'b0;
   localparam logic OP_TOGGLE = 1'b1;

   // Owner / round-robin pointer encoding
   localparam logic OWN_A = 1'b0;
   localparam logic OWN_B = 1'b1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLockA = 2'd1,
      StLockB = 2'd2
   } arb_state_e;

endpackage

// File: rtl/t_ff_bank.sv
// Bank of W T flip-flops with a shared enable and synchronous active-high reset.
module t_ff_bank #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] t,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // Toggle every bit whose enable is set
   always_comb begin
      q_d = q_q;
      if (en) begin
         q_d = q_q ^ t;
      end
   end

   // Bank state register
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter sharing one T flip-flop bank between requesters A and B,
// with an optional bounded lock that keeps ownership for back-to-back grants.
module tff_bank_arbiter
   import tff_arb_pkg::*;
#(
   parameter int unsigned W        = 4,
   parameter int unsigned MAX_LOCK = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_a,
   input  logic         op_a,
   input  logic [W-1:0] data_a,
   input  logic         lock_a,
   output logic         gnt_a,
   input  logic         req_b,
   input  logic         op_b,
   input  logic [W-1:0] data_b,
   input  logic         lock_b,
   output logic         gnt_b,
   output logic [W-1:0] q,
   output logic         upd,
   output logic         owner
);

   // Counter holds grants already taken in the current lock: 1..MAX_LOCK-1
   localparam int unsigned CntW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(MAX_LOCK - 1);

   arb_state_e    state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic          ptr_q, ptr_d;
   logic          owner_q, owner_d;
   logic          upd_q, upd_d;

   logic          bank_en;
   logic          sel_op;
   logic [W-1:0]  sel_data;
   logic [W-1:0]  bank_t;

   // Grant decision and FSM next state; reset suppresses every grant
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gnt_a   = 1'b0;
      gnt_b   = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StIdle: begin
               if (req_a && (!req_b || ptr_q == OWN_B)) begin
                  gnt_a = 1'b1;
               end else if (req_b) begin
                  gnt_b = 1'b1;
               end
               if (gnt_a) begin
                  ptr_d = OWN_A;
                  if (lock_a && MAX_LOCK > 1) begin
                     state_d = StLockA;
                     cnt_d   = CntW'(1);
                  end
               end
               if (gnt_b) begin
                  ptr_d = OWN_B;
                  if (lock_b && MAX_LOCK > 1) begin
                     state_d = StLockB;
                     cnt_d   = CntW'(1);
                  end
               end
            end
            StLockA: begin
               gnt_a = req_a;
               if (req_a && lock_a && cnt_q < CntLast) begin
                  cnt_d = cnt_q + 1'b1;
               end else begin
                  // Lock ends: hand the next tie to B
                  state_d = StIdle;
                  cnt_d   = '0;
                  ptr_d   = OWN_A;
               end
            end
            StLockB: begin
               gnt_b = req_b;
               if (req_b && lock_b && cnt_q < CntLast) begin
                  cnt_d = cnt_q + 1'b1;
               end else begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  ptr_d   = OWN_B;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Granted operation converted to toggle enables; a load uses T = D ^ q
   always_comb begin
      bank_en  = gnt_a | gnt_b;
      sel_op   = gnt_b ? op_b : op_a;
      sel_data = gnt_b ? data_b : data_a;
      bank_t   = (sel_op == OP_TOGGLE) ? sel_data : (sel_data ^ q);
      upd_d    = bank_en;
      owner_d  = owner_q;
      if (gnt_a) begin
         owner_d = OWN_A;
      end else if (gnt_b) begin
         owner_d = OWN_B;
      end
   end

   // Arbiter state, pointer and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ptr_q   <= OWN_B;
         owner_q <= OWN_B;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         upd_q   <= upd_d;
      end
   end

   t_ff_bank #(
      .W (W)
   ) u_bank (
      .clk (clk),
      .rst (rst),
      .en  (bank_en),
      .t   (bank_t),
      .q   (q)
   );

   assign upd   = upd_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Scoreboard bench: the driver runs a behavioural model and queues expectations,
// a negedge monitor compares them against the DUT.
module tb_tff_bank_arbiter;

   localparam int unsigned W        = 4;
   localparam int unsigned MAX_LOCK = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req_a = 1'b0, op_a = 1'b0, lock_a = 1'b0;
   logic         req_b = 1'b0, op_b = 1'b0, lock_b = 1'b0;
   logic [W-1:0] data_a = '0, data_b = '0;
   logic         gnt_a, gnt_b, upd, owner;
   logic [W-1:0] q;

   always #5 clk = ~clk;

   tff_bank_arbiter #(
      .W        (W),
      .MAX_LOCK (MAX_LOCK)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req_a  (req_a),
      .op_a   (op_a),
      .data_a (data_a),
      .lock_a (lock_a),
      .gnt_a  (gnt_a),
      .req_b  (req_b),
      .op_b   (op_b),
      .data_b (data_b),
      .lock_b (lock_b),
      .gnt_b  (gnt_b),
      .q      (q),
      .upd    (upd),
      .owner  (owner)
   );

   typedef struct {
      logic         ga;
      logic         gb;
      logic [W-1:0] q;
      logic         upd;
      logic         owner;
      bit           known;
   } cyc_t;

   typedef struct {
      logic [W-1:0] q;
      logic         owner;
   } res_t;

   cyc_t cyc_q[$];
   res_t res_q[$];

   int vectors     = 0;
   int checks      = 0;
   int miscompares = 0;

   // Behavioural model: lock holder (-1 none), grants taken in the lock, last winner
   logic [W-1:0] m_q      = '0;
   logic         m_owner  = 1'b1;
   logic         m_upd    = 1'b0;
   logic         m_last_b = 1'b1;
   int           m_lock   = -1;
   int           m_streak = 0;
   bit           m_known  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic ra, input logic oa, input logic [W-1:0] da,
                       input logic la, input logic rb, input logic ob,
                       input logic [W-1:0] db, input logic lb);
      cyc_t         e;
      res_t         rs;
      int           win;
      logic [W-1:0] d;
      logic         op, lk;
      @(posedge clk);
      #1;
      rst = r;
      req_a = ra; op_a = oa; data_a = da; lock_a = la;
      req_b = rb; op_b = ob; data_b = db; lock_b = lb;
      vectors++;
      e.q = m_q; e.upd = m_upd; e.owner = m_owner; e.known = m_known;
      win = -1;
      if (!r) begin
         if (m_lock == 0) begin
            if (ra) win = 0;
         end else if (m_lock == 1) begin
            if (rb) win = 1;
         end else if (ra && rb) begin
            win = m_last_b ? 0 : 1;
         end else if (ra) begin
            win = 0;
         end else if (rb) begin
            win = 1;
         end
      end
      e.ga = (win == 0);
      e.gb = (win == 1);
      cyc_q.push_back(e);
      if (r) begin
         m_q = '0; m_upd = 1'b0; m_owner = 1'b1; m_last_b = 1'b1;
         m_lock = -1; m_streak = 0; m_known = 1'b1;
      end else begin
         m_upd = (win >= 0);
         if (win >= 0) begin
            d  = (win == 1) ? db : da;
            op = (win == 1) ? ob : oa;
            lk = (win == 1) ? lb : la;
            m_q = op ? (m_q ^ d) : d;
            m_owner  = (win == 1);
            m_last_b = (win == 1);
            if (m_lock < 0) begin
               m_streak = 1;
               if (lk && MAX_LOCK > 1) m_lock = win;
            end else begin
               m_streak++;
               if (!lk || m_streak >= MAX_LOCK) m_lock = -1;
            end
            if (m_known) begin
               rs.q = m_q; rs.owner = m_owner;
               res_q.push_back(rs);
            end
         end else if (m_lock >= 0) begin
            m_last_b = (m_lock == 1);
            m_lock   = -1;
         end
      end
   endtask

   // Monitor: per-cycle grant/state checks and result pop on every update pulse
   cyc_t mon_e;
   res_t mon_r;
   always @(negedge clk) begin
      if (cyc_q.size() > 0) begin
         mon_e = cyc_q.pop_front();
         chk("gnt_a", 32'(gnt_a), 32'(mon_e.ga));
         chk("gnt_b", 32'(gnt_b), 32'(mon_e.gb));
         chk("gnt_exclusive", 32'(gnt_a & gnt_b), 32'(0));
         if (mon_e.known) begin
            chk("q", 32'(q), 32'(mon_e.q));
            chk("upd", 32'(upd), 32'(mon_e.upd));
            chk("owner", 32'(owner), 32'(mon_e.owner));
            if (upd === 1'b1) begin
               if (res_q.size() == 0) begin
                  chk("upd_unexpected", 32'(upd), 32'(0));
               end else begin
                  mon_r = res_q.pop_front();
                  chk("result_q", 32'(q), 32'(mon_r.q));
                  chk("result_owner", 32'(owner), 32'(mon_r.owner));
               end
            end
         end
      end
   end

   initial begin
      // Reset held two cycles while A requests a load of F
      step(1, 1, 0, 4'hF, 0, 0, 0, 4'h0, 0);
      step(1, 1, 0, 4'hF, 0, 0, 0, 4'h0, 0);
      // Single requester: load A, toggle 3
      step(0, 1, 0, 4'hA, 0, 0, 0, 4'h0, 0);
      step(0, 1, 1, 4'h3, 0, 0, 0, 4'h0, 0);
      step(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
      // Round-robin with both requesting, no lock
      for (int i = 0; i < 6; i++) step(0, 1, 0, 4'h1, 0, 1, 0, 4'h2, 0);
      // Lock bound: A locks continuously, B keeps requesting
      for (int i = 0; i < 5; i++) step(0, 1, 1, 4'h4, 1, 1, 1, 4'h8, 0);
      step(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
      // Lock release: one locked grant, then drop lock with req held
      step(0, 1, 0, 4'h5, 1, 0, 0, 4'h0, 0);
      step(0, 1, 1, 4'h1, 0, 1, 0, 4'hC, 0);
      step(0, 1, 0, 4'h7, 0, 1, 0, 4'hC, 0);
      step(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
      // Reset mid-lock: pending op discarded, first tie goes to A
      step(0, 1, 0, 4'h6, 1, 0, 0, 4'h0, 0);
      step(1, 1, 0, 4'hF, 1, 1, 0, 4'h9, 0);
      step(0, 1, 0, 4'h3, 0, 1, 0, 4'h9, 0);
      step(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), W'($urandom),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), W'($urandom),
              1'($urandom_range(0, 1)));
      end
      step(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
      step(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      #1;
      chk("results_drained", 32'(res_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
